fetch_prefetch_queue: RTL and testbench

- Instruction prefetcher between instruction memory and the ID slice.
- Issues word fetches to a variable-latency instruction memory, buffers returned words with their PC_inc in a small FIFO, and presents the FIFO head to ID.
- Handles stall hold, halt, and Call/Branch/Ret redirects by flushing buffered and in-flight fetches.

---
 rtl/fetch_prefetch_queue.sv | 82 ++++++++
 tb/tb_fetch_prefetch_queue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: single-outstanding instruction prefetcher with a small FIFO feeding ID
module fetch_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hlt,
  input  logic        stall,
  input  logic        Call,
  input  logic [15:0] PCcall,
  input  logic        Branch,
  input  logic [15:0] PCbranch,
  input  logic        Ret,
  input  logic [15:0] PCret,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] PC_inc
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t state, state_nx;
  logic [15:0] fetch_pc, req_addr, last_pc_inc, target;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [15:0] fifo_instr [DEPTH];
  logic [15:0] fifo_pc_inc [DEPTH];
  logic redirect, issue, push, pop;
  assign redirect = Ret | Branch | Call;
  assign target = Ret ? PCret : Branch ? PCbranch : PCcall;
  // an empty slot is required before issuing, so the in-flight word always has room
  assign issue = !rst && state == IDLE && !hlt && !redirect && count < (AW+1)'(DEPTH);
  assign push = state == WAIT && imem_rvalid && !redirect;
  assign pop = instr_valid && !stall && !redirect;
  assign imem_req = issue;
  assign imem_addr = fetch_pc;
  assign instr_valid = count != '0;
  assign instr = instr_valid ? fifo_instr[rd_ptr] : NOP_INSTR;
  assign PC_inc = instr_valid ? fifo_pc_inc[rd_ptr] : last_pc_inc;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (issue ? WAIT : IDLE) :
               state == WAIT ? (imem_rvalid ? IDLE : redirect ? DROP : WAIT) :
               state == DROP ? (imem_rvalid ? IDLE : DROP) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      last_pc_inc <= '0;
    end else begin
      state <= state_nx;
      fetch_pc <= redirect ? target : issue ? fetch_pc + 16'd1 : fetch_pc;
      if (issue) req_addr <= fetch_pc;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
      if (pop) last_pc_inc <= fifo_pc_inc[rd_ptr];
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc_inc[wr_ptr] <= req_addr + 16'd1;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: directed stimulus with a decoupled scoreboard monitor for the prefetcher
module tb_fetch_prefetch_queue;
  logic clk = 0, rst = 1, hlt = 0, stall = 0, Call = 0, Branch = 0, Ret = 0;
  logic [15:0] PCcall = 0, PCbranch = 0, PCret = 0;
  logic imem_req, imem_rvalid = 0, instr_valid;
  logic [15:0] imem_addr, imem_rdata = 0, instr, PC_inc;
  logic imem_req2, imem_rvalid2 = 0, instr_valid2;
  logic [15:0] imem_addr2, imem_rdata2 = 0, instr2, PC_inc2;
  int checks = 0, errors = 0, lat = 1, n;
  typedef struct packed {logic [15:0] i; logic [15:0] p;} out_t;
  logic [15:0] exp_addr [$];
  out_t exp_out [$];
  bit mbusy [2];
  int mcnt [2];
  logic [15:0] maddr [2];

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk(clk), .rst(rst), .hlt(hlt), .stall(stall),
    .Call(Call), .PCcall(PCcall), .Branch(Branch), .PCbranch(PCbranch), .Ret(Ret), .PCret(PCret),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .PC_inc(PC_inc));

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFF), .NOP_INSTR(16'h0000)) dut2 (
    .clk(clk), .rst(rst), .hlt(hlt), .stall(stall),
    .Call(Call), .PCcall(PCcall), .Branch(Branch), .PCbranch(PCbranch), .Ret(Ret), .PCret(PCret),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .instr_valid(instr_valid2), .instr(instr2), .PC_inc(PC_inc2));

  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [15:0] a);
    return a ^ 16'hBEEF;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // memory models: fixed latency lat, data = word(addr); also flags a second outstanding request
  always @(negedge clk) begin : mem
    logic rq [2];
    logic rv [2];
    logic [15:0] ra [2];
    logic [15:0] rd [2];
    rq[0] = imem_req; rq[1] = imem_req2;
    ra[0] = imem_addr; ra[1] = imem_addr2;
    for (int k = 0; k < 2; k++) begin
      rv[k] = 0;
      rd[k] = 16'h0;
      if (mbusy[k]) begin
        mcnt[k]--;
        if (mcnt[k] == 0) begin
          rv[k] = 1;
          rd[k] = word(maddr[k]);
          mbusy[k] = 0;
        end
      end
      if (rq[k]) begin
        checks++;
        if (mbusy[k]) begin
          errors++;
          $display("FAIL outstanding dut%0d got 2 exp 1", k);
        end
        mbusy[k] = 1;
        maddr[k] = ra[k];
        mcnt[k] = lat;
      end
    end
    imem_rvalid = rv[0]; imem_rdata = rd[0];
    imem_rvalid2 = rv[1]; imem_rdata2 = rd[1];
  end

  always @(negedge clk) begin : mon
    out_t e;
    if (!rst) begin
      if (imem_req && exp_addr.size() != 0) chk("imem_addr", imem_addr, exp_addr.pop_front());
      if (instr_valid && !stall && !(Ret | Branch | Call) && exp_out.size() != 0) begin
        e = exp_out.pop_front();
        chk("pop_instr", instr, e.i);
        chk("pop_PC_inc", PC_inc, e.p);
      end
    end
  end

  task automatic step(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hlt = 1; stall = 0; Ret = 0; Branch = 0; Call = 0; rst = 1;
    step(5);
    exp_addr.delete();
    exp_out.delete();
  endtask

  task automatic drain(input string name, input int bound, output int cyc);
    cyc = 0;
    while ((exp_addr.size() != 0 || exp_out.size() != 0) && cyc < bound) begin
      step();
      cyc++;
    end
    chk(name, 16'(exp_addr.size() + exp_out.size()), 16'h0);
  endtask

  task automatic wait_addr(input int left, input int bound);
    int c = 0;
    while (exp_addr.size() > left && c < bound) begin
      step();
      c++;
    end
    chk("wait_addr_left", 16'(exp_addr.size()), 16'(left));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    step(2);
    chk("rst_req", 16'(imem_req), 16'h0);
    chk("rst_valid", 16'(instr_valid), 16'h0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_PC_inc", PC_inc, 16'h0000);
    // streaming with 1-cycle memory
    lat = 1;
    for (int i = 0; i < 6; i++) exp_addr.push_back(16'(i));
    for (int i = 0; i < 5; i++) exp_out.push_back('{word(16'(i)), 16'(i + 1)});
    rst = 0;
    drain("stream_drain", 40, n);
    chk("throughput_cycles", 16'(n), 16'd11);
    // full FIFO under stall, 3-cycle memory
    do_reset();
    lat = 3; stall = 1; hlt = 0;
    for (int i = 0; i < 4; i++) exp_addr.push_back(16'(i));
    rst = 0;
    step(24);
    chk("full_issued_left", 16'(exp_addr.size()), 16'h0);
    chk("full_req", 16'(imem_req), 16'h0);
    chk("full_valid", 16'(instr_valid), 16'h1);
    chk("full_instr", instr, word(16'h0));
    chk("full_PC_inc", PC_inc, 16'h0001);
    exp_out.push_back('{word(16'h0), 16'h0001});
    exp_addr.push_back(16'h0004);
    stall = 0;
    step();
    stall = 1;
    chk("resume_req", 16'(imem_req), 16'h1);
    chk("resume_addr", imem_addr, 16'h0004);
    step(4);
    chk("hold_instr", instr, word(16'h1));
    chk("hold_PC_inc", PC_inc, 16'h0002);
    drain("resume_drain", 10, n);
    // branch redirect with a fetch to 0x0005 in flight
    do_reset();
    lat = 3; hlt = 0;
    for (int i = 0; i < 6; i++) exp_addr.push_back(16'(i));
    exp_addr.push_back(16'h0040);
    for (int i = 0; i < 3; i++) exp_out.push_back('{word(16'(i)), 16'(i + 1)});
    exp_out.push_back('{word(16'h0040), 16'h0041});
    rst = 0;
    wait_addr(3, 40);
    stall = 1;
    wait_addr(1, 40);
    chk("pre_branch_valid", 16'(instr_valid), 16'h1);
    chk("pre_branch_instr", instr, word(16'h3));
    Branch = 1; PCbranch = 16'h0040;
    step();
    Branch = 0; stall = 0;
    chk("flush_valid", 16'(instr_valid), 16'h0);
    chk("flush_instr", instr, 16'h0000);
    chk("flush_PC_inc", PC_inc, 16'h0003);
    chk("drop_req", 16'(imem_req), 16'h0);
    drain("branch_drain", 40, n);
    // redirect priority while halted
    do_reset();
    lat = 1;
    rst = 0;
    step();
    Ret = 1; PCret = 16'h0100; Call = 1; PCcall = 16'h0200;
    exp_addr.push_back(16'h0100);
    exp_out.push_back('{word(16'h0100), 16'h0101});
    step();
    Ret = 0; Call = 0; hlt = 0;
    drain("ret_call_drain", 20, n);
    hlt = 1;
    step(4);
    Ret = 1; PCret = 16'h0300; Branch = 1; PCbranch = 16'h0400; Call = 1; PCcall = 16'h0500;
    exp_addr.push_back(16'h0300);
    exp_out.push_back('{word(16'h0300), 16'h0301});
    step();
    Ret = 0; Branch = 0; Call = 0;
    chk("ret_branch_flush", 16'(instr_valid), 16'h0);
    hlt = 0;
    drain("ret_branch_drain", 20, n);
    // halt mid-fetch
    do_reset();
    lat = 3; stall = 1; hlt = 0;
    exp_addr.push_back(16'h0000);
    rst = 0;
    step();
    hlt = 1;
    step(6);
    chk("hlt_req", 16'(imem_req), 16'h0);
    chk("hlt_valid", 16'(instr_valid), 16'h1);
    chk("hlt_instr", instr, word(16'h0));
    chk("hlt_PC_inc", PC_inc, 16'h0001);
    exp_out.push_back('{word(16'h0), 16'h0001});
    exp_addr.push_back(16'h0001);
    stall = 0;
    step();
    chk("hlt_empty_valid", 16'(instr_valid), 16'h0);
    chk("hlt_empty_instr", instr, 16'h0000);
    chk("hlt_empty_PC_inc", PC_inc, 16'h0001);
    chk("hlt_still_no_req", 16'(imem_req), 16'h0);
    hlt = 0;
    drain("hlt_resume_drain", 20, n);
    // RESET_PC = 0xFFFF wraps to 0x0000
    do_reset();
    lat = 1; stall = 1; hlt = 0;
    rst = 0;
    #1;
    chk("wrap_req0", 16'(imem_req2), 16'h1);
    chk("wrap_addr0", imem_addr2, 16'hFFFF);
    step(2);
    chk("wrap_req1", 16'(imem_req2), 16'h1);
    chk("wrap_addr1", imem_addr2, 16'h0000);
    chk("wrap_valid", 16'(instr_valid2), 16'h1);
    chk("wrap_instr", instr2, word(16'hFFFF));
    chk("wrap_PC_inc", PC_inc2, 16'h0000);
    // reset while waiting: the late response is dropped
    do_reset();
    lat = 3; stall = 0; hlt = 0;
    rst = 0;
    step();
    rst = 1; hlt = 1;
    step();
    rst = 0;
    step(4);
    chk("late_rvalid_valid", 16'(instr_valid), 16'h0);
    chk("late_rvalid_instr", instr, 16'h0000);
    chk("late_rvalid_req", 16'(imem_req), 16'h0);
    chk("late_rvalid_valid2", 16'(instr_valid2), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
